// File: rtl/hp_mem_responder.sv
// ---------------------------------------------------------------------------
// hp_mem_responder
//   AXI4 burst slave standing in for DDR behind the kernel's HP master port.
//   Backs accesses with DEPTH 128-bit words starting at byte BASE_ADDR and
//   accepts 16-byte-beat INCR bursts. One write and one read may be in flight
//   at a time; the two channels are independent and run concurrently.
//   Exposes running beat counts so the host can cross-check kernel traffic.
//
// Ports
//   clk, rstn                      clock, asynchronous active-low reset
//   hp_aw* / hp_awready            write address channel
//   hp_w*  / hp_wready             write data channel
//   hp_b*  / hp_bready             write response channel
//   hp_ar* / hp_arready            read address channel
//   hp_r*  / hp_rready             read data channel
//   wr_beats, rd_beats             accepted W / R beats since reset (wrapping)
//
// Error decoding is done once per burst at the address handshake:
//   outside the window or not 16-byte aligned      -> DECERR (2'b11)
//   wrong size or non-INCR burst                   -> SLVERR (2'b10)
//   Failed bursts still run to completion: writes are dropped, reads return 0.
//   Bursts running past the top of the window wrap to word 0.
// ---------------------------------------------------------------------------
module hp_mem_responder #(
  parameter int                       HP_ADDR_WIDTH = 48,
  parameter int                       HP_DATA_WIDTH = 128,
  parameter int                       DEPTH         = 4096,
  parameter logic [HP_ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  // write address
  input  logic [HP_ADDR_WIDTH-1:0]   hp_awaddr,
  input  logic [7:0]                 hp_awlen,
  input  logic [2:0]                 hp_awsize,
  input  logic [1:0]                 hp_awburst,
  input  logic                       hp_awvalid,
  output logic                       hp_awready,
  // write data
  input  logic [HP_DATA_WIDTH-1:0]   hp_wdata,
  input  logic [HP_DATA_WIDTH/8-1:0] hp_wstrb,
  input  logic                       hp_wlast,
  input  logic                       hp_wvalid,
  output logic                       hp_wready,
  // write response
  output logic [1:0]                 hp_bresp,
  output logic                       hp_bvalid,
  input  logic                       hp_bready,
  // read address
  input  logic [HP_ADDR_WIDTH-1:0]   hp_araddr,
  input  logic [7:0]                 hp_arlen,
  input  logic [2:0]                 hp_arsize,
  input  logic [1:0]                 hp_arburst,
  input  logic                       hp_arvalid,
  output logic                       hp_arready,
  // read data
  output logic [HP_DATA_WIDTH-1:0]   hp_rdata,
  output logic [1:0]                 hp_rresp,
  output logic                       hp_rlast,
  output logic                       hp_rvalid,
  input  logic                       hp_rready,
  // traffic counters
  output logic [31:0]                wr_beats,
  output logic [31:0]                rd_beats
);

  localparam int STRB_W = HP_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [IDX_W-1:0]         IDX_ONE   = 1;
  localparam logic [HP_ADDR_WIDTH:0]   WIN_BYTES = (HP_ADDR_WIDTH + 1)'(DEPTH) << 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Offset is one bit wider than the address so an address below BASE_ADDR
  // wraps to a huge value and fails the window compare on its own.
  // BASE_ADDR is assumed 16-byte aligned, so off[3:0] equals addr[3:0].
  function automatic logic [1:0] decode_resp(input logic [HP_ADDR_WIDTH:0] off,
                                             input logic [2:0]             size,
                                             input logic [1:0]             burst);
    if (off >= WIN_BYTES || off[3:0] != 4'h0) return RESP_DECERR;
    if (size != 3'd4 || burst != 2'b01)        return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic [HP_DATA_WIDTH-1:0] mem [DEPTH];

  logic [HP_ADDR_WIDTH:0] aw_off, ar_off;
  logic [1:0]             aw_resp, ar_resp;
  logic [IDX_W-1:0]       aw_idx, ar_idx;

  assign aw_off  = {1'b0, hp_awaddr} - {1'b0, BASE_ADDR};
  assign ar_off  = {1'b0, hp_araddr} - {1'b0, BASE_ADDR};
  assign aw_resp = decode_resp(aw_off, hp_awsize, hp_awburst);
  assign ar_resp = decode_resp(ar_off, hp_arsize, hp_arburst);
  assign aw_idx  = aw_off[IDX_W+3:4];
  assign ar_idx  = ar_off[IDX_W+3:4];

  // ------------------------------------------------------------------ write
  w_state_e         w_state_q, w_state_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]       w_len_q, w_len_d;
  logic [7:0]       w_cnt_q, w_cnt_d;
  logic [1:0]       w_resp_q, w_resp_d;
  logic             w_drop_q, w_drop_d;
  logic [31:0]      wr_beats_q, wr_beats_d;
  logic             awready_q, wready_q, bvalid_q;
  logic             w_fire;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_d  = w_state_q;
    w_idx_d    = w_idx_q;
    w_len_d    = w_len_q;
    w_cnt_d    = w_cnt_q;
    w_resp_d   = w_resp_q;
    w_drop_d   = w_drop_q;
    wr_beats_d = wr_beats_q;
    w_fire     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (hp_awvalid && awready_q) begin
          w_idx_d   = aw_idx;
          w_len_d   = hp_awlen;
          w_cnt_d   = 8'd0;
          w_resp_d  = aw_resp;
          w_drop_d  = (aw_resp != RESP_OKAY);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (hp_wvalid && wready_q) begin
          w_fire     = 1'b1;
          w_idx_d    = w_idx_q + IDX_ONE;
          w_cnt_d    = w_cnt_q + 8'd1;
          wr_beats_d = wr_beats_q + 32'd1;
          // A misplaced wlast only taints the response; the beat count from
          // awlen still decides where the burst ends.
          if ((hp_wlast != (w_cnt_q == w_len_q)) && (w_resp_q == RESP_OKAY))
            w_resp_d = RESP_SLVERR;
          if (w_cnt_q == w_len_q)
            w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (hp_bready && bvalid_q) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they read 0
  // while reset is held and never glitch combinationally.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q  <= W_IDLE;
      w_idx_q    <= '0;
      w_len_q    <= 8'd0;
      w_cnt_q    <= 8'd0;
      w_resp_q   <= RESP_OKAY;
      w_drop_q   <= 1'b0;
      wr_beats_q <= 32'd0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      w_idx_q    <= w_idx_d;
      w_len_q    <= w_len_d;
      w_cnt_q    <= w_cnt_d;
      w_resp_q   <= w_resp_d;
      w_drop_q   <= w_drop_d;
      wr_beats_q <= wr_beats_d;
      awready_q  <= (w_state_d == W_IDLE);
      wready_q   <= (w_state_d == W_DATA);
      bvalid_q   <= (w_state_d == W_RESP);
    end
  end

  // NOTE: the storage array has no reset; contents survive rstn and a reset
  // port on it would prevent mapping to RAM.
  always_ff @(posedge clk) begin
    if (w_fire && !w_drop_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (hp_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= hp_wdata[b*8 +: 8];
      end
    end
  end

  // ------------------------------------------------------------------- read
  r_state_e                 r_state_q, r_state_d;
  logic [IDX_W-1:0]         r_idx_q, r_idx_d;     // next word to load
  logic [7:0]               r_len_q, r_len_d;
  logic [7:0]               r_cnt_q, r_cnt_d;     // beat currently presented
  logic [1:0]               rresp_q, rresp_d;
  logic [HP_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                     rlast_q, rlast_d;
  logic [31:0]              rd_beats_q, rd_beats_d;
  logic                     arready_q, rvalid_q;

  // The array is read combinationally and captured at the edge, so a write
  // to the same word on that edge is not yet visible: read-before-write.
  always_comb begin
    r_state_d  = r_state_q;
    r_idx_d    = r_idx_q;
    r_len_d    = r_len_q;
    r_cnt_d    = r_cnt_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rlast_d    = rlast_q;
    rd_beats_d = rd_beats_q;
    case (r_state_q)
      R_IDLE: begin
        if (hp_arvalid && arready_q) begin
          r_len_d   = hp_arlen;
          r_cnt_d   = 8'd0;
          rresp_d   = ar_resp;
          rdata_d   = (ar_resp == RESP_OKAY) ? mem[ar_idx] : '0;
          rlast_d   = (hp_arlen == 8'd0);
          r_idx_d   = ar_idx + IDX_ONE;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (hp_rready && rvalid_q) begin
          rd_beats_d = rd_beats_q + 32'd1;
          if (r_cnt_q == r_len_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            // Load the following beat on the accepting edge for full rate.
            r_cnt_d = r_cnt_q + 8'd1;
            r_idx_d = r_idx_q + IDX_ONE;
            rdata_d = (rresp_q == RESP_OKAY) ? mem[r_idx_q] : '0;
            rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q  <= R_IDLE;
      r_idx_q    <= '0;
      r_len_q    <= 8'd0;
      r_cnt_q    <= 8'd0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
      rd_beats_q <= 32'd0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_idx_q    <= r_idx_d;
      r_len_q    <= r_len_d;
      r_cnt_q    <= r_cnt_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      rlast_q    <= rlast_d;
      rd_beats_q <= rd_beats_d;
      arready_q  <= (r_state_d == R_IDLE);
      rvalid_q   <= (r_state_d == R_DATA);
    end
  end

  // ---------------------------------------------------------------- outputs
  assign hp_awready = awready_q;
  assign hp_wready  = wready_q;
  assign hp_bvalid  = bvalid_q;
  assign hp_bresp   = w_resp_q;
  assign hp_arready = arready_q;
  assign hp_rvalid  = rvalid_q;
  assign hp_rdata   = rdata_q;
  assign hp_rresp   = rresp_q;
  assign hp_rlast   = rlast_q;
  assign wr_beats   = wr_beats_q;
  assign rd_beats   = rd_beats_q;

endmodule

// File: tb/tb_hp_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_hp_mem_responder
//   Directed bench for hp_mem_responder with a small 16-word window at
//   0x1000 (window = [0x1000, 0x1100)). Inputs are driven 1 time unit after
//   the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hp_mem_responder;

  localparam int          AW    = 48;
  localparam int          DW    = 128;
  localparam int          DEPTH = 16;
  localparam logic [47:0] BASE  = 48'h1000;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] hp_awaddr, hp_araddr;
  logic [7:0]    hp_awlen, hp_arlen;
  logic [2:0]    hp_awsize, hp_arsize;
  logic [1:0]    hp_awburst, hp_arburst;
  logic          hp_awvalid, hp_awready;
  logic [DW-1:0] hp_wdata;
  logic [15:0]   hp_wstrb;
  logic          hp_wlast, hp_wvalid, hp_wready;
  logic [1:0]    hp_bresp;
  logic          hp_bvalid, hp_bready;
  logic          hp_arvalid, hp_arready;
  logic [DW-1:0] hp_rdata;
  logic [1:0]    hp_rresp;
  logic          hp_rlast, hp_rvalid, hp_rready;
  logic [31:0]   wr_beats, rd_beats;

  hp_mem_responder #(
    .HP_ADDR_WIDTH (AW),
    .HP_DATA_WIDTH (DW),
    .DEPTH         (DEPTH),
    .BASE_ADDR     (BASE)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .hp_awaddr  (hp_awaddr),
    .hp_awlen   (hp_awlen),
    .hp_awsize  (hp_awsize),
    .hp_awburst (hp_awburst),
    .hp_awvalid (hp_awvalid),
    .hp_awready (hp_awready),
    .hp_wdata   (hp_wdata),
    .hp_wstrb   (hp_wstrb),
    .hp_wlast   (hp_wlast),
    .hp_wvalid  (hp_wvalid),
    .hp_wready  (hp_wready),
    .hp_bresp   (hp_bresp),
    .hp_bvalid  (hp_bvalid),
    .hp_bready  (hp_bready),
    .hp_araddr  (hp_araddr),
    .hp_arlen   (hp_arlen),
    .hp_arsize  (hp_arsize),
    .hp_arburst (hp_arburst),
    .hp_arvalid (hp_arvalid),
    .hp_arready (hp_arready),
    .hp_rdata   (hp_rdata),
    .hp_rresp   (hp_rresp),
    .hp_rlast   (hp_rlast),
    .hp_rvalid  (hp_rvalid),
    .hp_rready  (hp_rready),
    .wr_beats   (wr_beats),
    .rd_beats   (rd_beats)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] ev [8];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expd);
    n_cmp++;
    assert (obs === expd) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
    end
  endtask

  task automatic aw_hs(input logic [47:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit ok = 1'b0;
    hp_awaddr = a; hp_awlen = len; hp_awsize = size; hp_awburst = burst;
    hp_awvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (hp_awready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    hp_awvalid = 1'b0;
    check("aw_handshake", DW'(ok), DW'(1));
  endtask

  task automatic ar_hs(input logic [47:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit ok = 1'b0;
    hp_araddr = a; hp_arlen = len; hp_arsize = size; hp_arburst = burst;
    hp_arvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (hp_arready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    hp_arvalid = 1'b0;
    check("ar_handshake", DW'(ok), DW'(1));
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [15:0] s, input logic l);
    bit ok = 1'b0;
    hp_wdata = d; hp_wstrb = s; hp_wlast = l;
    hp_wvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (hp_wready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    hp_wvalid = 1'b0;
    check("w_handshake", DW'(ok), DW'(1));
  endtask

  // Called right after the final W beat: bvalid must already be up.
  task automatic b_resp(input string tag, input logic [1:0] expd);
    hp_bready = 1'b1;
    @(negedge clk);
    check({tag, "_bvalid"}, DW'(hp_bvalid), DW'(1));
    check({tag, "_bresp"}, DW'(hp_bresp), DW'(expd));
    @(posedge clk); #1;
    hp_bready = 1'b0;
    @(negedge clk);
    check({tag, "_bvalid_drop"}, DW'(hp_bvalid), DW'(0));
    @(posedge clk); #1;
  endtask

  task automatic rd_burst(input string tag, input logic [47:0] a, input logic [7:0] len,
                          input logic [1:0] burst, input logic [1:0] resp,
                          input logic [DW-1:0] expd [8], input bit toggle);
    int            beat    = 0;
    bit            stalled = 1'b0;
    logic [DW-1:0] prev    = '0;
    hp_rready = 1'b1;
    ar_hs(a, len, 3'd4, burst);
    @(negedge clk);
    check({tag, "_latency"}, DW'(hp_rvalid), DW'(1));
    for (int c = 0; c < 64 && beat <= int'(len); c++) begin
      if (c > 0) @(negedge clk);
      if (hp_rvalid === 1'b1) begin
        check({tag, "_rdata"}, hp_rdata, expd[beat]);
        check({tag, "_rlast"}, DW'(hp_rlast), DW'(beat == int'(len)));
        check({tag, "_rresp"}, DW'(hp_rresp), DW'(resp));
        if (stalled) check({tag, "_stall_stable"}, hp_rdata, prev);
        prev    = hp_rdata;
        stalled = !hp_rready;
        if (hp_rready) beat++;
      end
      @(posedge clk); #1;
      if (toggle) hp_rready = ~hp_rready;
    end
    check({tag, "_beats"}, DW'(beat), DW'(int'(len) + 1));
    hp_rready = 1'b0;
    @(negedge clk);
    check({tag, "_rvalid_drop"}, DW'(hp_rvalid), DW'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0;
    hp_awaddr = '0; hp_awlen = '0; hp_awsize = '0; hp_awburst = '0; hp_awvalid = 1'b0;
    hp_wdata = '0; hp_wstrb = '0; hp_wlast = 1'b0; hp_wvalid = 1'b0; hp_bready = 1'b0;
    hp_araddr = '0; hp_arlen = '0; hp_arsize = '0; hp_arburst = '0; hp_arvalid = 1'b0;
    hp_rready = 1'b0;

    // ---- reset values
    #3;
    check("rst_awready", DW'(hp_awready), DW'(0));
    check("rst_wready",  DW'(hp_wready),  DW'(0));
    check("rst_bvalid",  DW'(hp_bvalid),  DW'(0));
    check("rst_arready", DW'(hp_arready), DW'(0));
    check("rst_rvalid",  DW'(hp_rvalid),  DW'(0));
    check("rst_bresp",   DW'(hp_bresp),   DW'(0));
    check("rst_rresp",   DW'(hp_rresp),   DW'(0));
    check("rst_rdata",   hp_rdata,        DW'(0));
    check("rst_rlast",   DW'(hp_rlast),   DW'(0));
    check("rst_wr_beats", DW'(wr_beats),  DW'(0));
    check("rst_rd_beats", DW'(rd_beats),  DW'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_awready", DW'(hp_awready), DW'(1));
    check("idle_arready", DW'(hp_arready), DW'(1));
    @(posedge clk); #1;

    // ---- 1: 4-beat write of k*0x11 to word 0
    aw_hs(BASE, 8'd3, 3'd4, 2'b01);
    for (int k = 0; k < 4; k++) w_beat(DW'(k * 17), 16'hFFFF, k == 3);
    b_resp("t1", 2'b00);
    check("t1_wr_beats", DW'(wr_beats), DW'(4));

    // ---- 2: read it back at full rate
    ev[0] = DW'(0); ev[1] = DW'(17); ev[2] = DW'(34); ev[3] = DW'(51);
    rd_burst("t2", BASE, 8'd3, 2'b01, 2'b00, ev, 1'b0);
    check("t2_rd_beats", DW'(rd_beats), DW'(4));

    // ---- 3: partial strobe over 0x55.. at word 5
    aw_hs(BASE + 48'h50, 8'd0, 3'd4, 2'b01);
    w_beat({8{16'h5555}}, 16'hFFFF, 1'b1);
    b_resp("t3a", 2'b00);
    aw_hs(BASE + 48'h50, 8'd0, 3'd4, 2'b01);
    w_beat({DW{1'b1}}, 16'h000F, 1'b1);
    b_resp("t3b", 2'b00);
    ev[0] = 128'h5555_5555_5555_5555_5555_5555_FFFF_FFFF;
    rd_burst("t3", BASE + 48'h50, 8'd0, 2'b01, 2'b00, ev, 1'b0);

    // ---- 4: errors
    for (int k = 0; k < 8; k++) ev[k] = '0;
    rd_burst("t4_decerr", BASE + 48'h100, 8'd1, 2'b01, 2'b11, ev, 1'b0);
    aw_hs(BASE, 8'd0, 3'd3, 2'b01);
    w_beat(128'hDEAD, 16'hFFFF, 1'b1);
    b_resp("t4_slverr", 2'b10);
    rd_burst("t4_unchanged", BASE, 8'd0, 2'b01, 2'b00, ev, 1'b0);
    rd_burst("t4_fixed", BASE + 48'h10, 8'd0, 2'b00, 2'b10, ev, 1'b0);

    // ---- early wlast: SLVERR, beat before the mismatch kept
    aw_hs(BASE + 48'h90, 8'd2, 3'd4, 2'b01);
    w_beat(128'h90, 16'hFFFF, 1'b0);
    w_beat(128'h91, 16'hFFFF, 1'b1);
    w_beat(128'h92, 16'hFFFF, 1'b1);
    b_resp("wlast", 2'b10);
    ev[0] = 128'h90;
    rd_burst("wlast_kept", BASE + 48'h90, 8'd0, 2'b01, 2'b00, ev, 1'b0);
    check("wlast_wr_beats", DW'(wr_beats), DW'(10));

    // ---- 5: 8-beat write wrapping past the top, then stalled read
    aw_hs(BASE + 48'hC0, 8'd7, 3'd4, 2'b01);
    for (int k = 0; k < 8; k++) w_beat(DW'(8'hA0 + k), 16'hFFFF, k == 7);
    b_resp("t5w", 2'b00);
    for (int k = 0; k < 8; k++) ev[k] = DW'(8'hA0 + k);
    rd_burst("t5", BASE + 48'hC0, 8'd7, 2'b01, 2'b00, ev, 1'b1);
    check("t5_rd_beats", DW'(rd_beats), DW'(18));
    check("t5_wr_beats", DW'(wr_beats), DW'(18));

    // ---- 6: reset during beat 2 of an 8-beat write
    aw_hs(BASE, 8'd7, 3'd4, 2'b01);
    w_beat(128'hB0, 16'hFFFF, 1'b0);
    w_beat(128'hB1, 16'hFFFF, 1'b0);
    hp_wdata = 128'hB2; hp_wstrb = 16'hFFFF; hp_wlast = 1'b0; hp_wvalid = 1'b1;
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    check("t6_awready", DW'(hp_awready), DW'(0));
    check("t6_wready",  DW'(hp_wready),  DW'(0));
    check("t6_bvalid",  DW'(hp_bvalid),  DW'(0));
    check("t6_arready", DW'(hp_arready), DW'(0));
    check("t6_rvalid",  DW'(hp_rvalid),  DW'(0));
    check("t6_wr_beats", DW'(wr_beats),  DW'(0));
    hp_wvalid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    aw_hs(BASE + 48'h20, 8'd0, 3'd4, 2'b01);
    w_beat(128'hC2, 16'hFFFF, 1'b1);
    b_resp("t6", 2'b00);
    check("t6_wr_after", DW'(wr_beats), DW'(1));
    ev[0] = 128'hB0; ev[1] = 128'hB1; ev[2] = 128'hC2;
    rd_burst("t6", BASE, 8'd2, 2'b01, 2'b00, ev, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
